// File: rtl/mixcol_pkg.sv
// ---------------------------------------------------------------------------
// mixcol_pkg
// Purpose : Shared definitions for the MixColumns engine: the FSM state type,
//           the GF(2^8) reduction constant, and the xtime / general GF(2^8)
//           multiply helpers used by the column transform.
// Ports   : none (package).
// Config  : the optional InvMixColumns datapath is enabled by defining
//           MIXCOL_INV_EN; nothing in this package depends on it.
// ---------------------------------------------------------------------------
package mixcol_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Low byte of the AES field polynomial x^8+x^4+x^3+x+1.
    localparam logic [7:0] GF_RED = 8'h1B;

    // Multiply by x (i.e. by 8'h02) in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
    endfunction

    // General GF(2^8) multiply. Callers pass a constant coefficient, so this
    // collapses to a handful of XORs after constant propagation.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] term;
        prod = 8'h00;
        term = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ term;
            end
            term = xtime(term);
        end
        return prod;
    endfunction

endpackage : mixcol_pkg

// File: rtl/mix_column_unit.sv
// ---------------------------------------------------------------------------
// mix_column_unit
// Purpose : Purely combinational transform of a single 32-bit AES column.
//           Forward mode applies the circulant matrix [2 3 1 1]; inverse mode
//           (only built when MIXCOL_INV_EN is defined) applies [0E 0B 0D 09].
// Ports   : col_in  [31:0] column, row 0 byte in bits [31:24]
//           inv            1 = inverse transform (ignored without MIXCOL_INV_EN)
//           col_out [31:0] transformed column, same byte order
// Config  : MIXCOL_INV_EN -- include the inverse datapath.
// ---------------------------------------------------------------------------
module mix_column_unit
    import mixcol_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0] a   [4];
    logic [7:0] fwd [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign a[gi] = col_in[31-8*gi -: 8];

            // Row gi is [2 3 1 1] rotated right by gi positions.
            assign fwd[gi] = xtime(a[gi])
                           ^ xtime(a[(gi+1)%4]) ^ a[(gi+1)%4]
                           ^ a[(gi+2)%4]
                           ^ a[(gi+3)%4];
        end
    endgenerate

`ifdef MIXCOL_INV_EN
    logic [7:0] bwd [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_inv_bytes
            assign bwd[gi] = gf_mul(a[gi],       8'h0E)
                           ^ gf_mul(a[(gi+1)%4], 8'h0B)
                           ^ gf_mul(a[(gi+2)%4], 8'h0D)
                           ^ gf_mul(a[(gi+3)%4], 8'h09);
            assign col_out[31-8*gi -: 8] = inv ? bwd[gi] : fwd[gi];
        end
    endgenerate
`else
    // Forward-only build: the mode input is accepted but has no effect.
    logic unused_inv;
    assign unused_inv = inv;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_out_bytes
            assign col_out[31-8*gi -: 8] = fwd[gi];
        end
    endgenerate
`endif

endmodule : mix_column_unit

// File: rtl/mix_columns_engine.sv
// ---------------------------------------------------------------------------
// mix_columns_engine
// Purpose : Iterative AES MixColumns / InvMixColumns over a 128-bit state.
//           A block is captured in IDLE, transformed in place COLS_PER_CYCLE
//           columns per clock (column 0 first) during BUSY, then held in DONE
//           until the consumer accepts it.
// Params  : COLS_PER_CYCLE  columns per clock: 1, 2 or 4 (latency 4, 2, 1)
// Ports   : clk        rising-edge clock
//           rst_n      asynchronous active-low reset
//           in_valid   block offered          in_ready  engine idle
//           in_data    128-bit state, column c at [127-32c -: 32]
//           in_inv     1 = inverse transform, sampled with in_data
//           out_valid  result held            out_ready consumer accepts
//           out_data   working register (meaningful only while out_valid)
//           busy       high whenever not IDLE
// Config  : MIXCOL_INV_EN -- when defined, in_inv selects InvMixColumns;
//           otherwise in_inv is ignored and only forward logic exists.
// ---------------------------------------------------------------------------
module mix_columns_engine
    import mixcol_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int K     = 4 / COLS_PER_CYCLE;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [127:0]       work_reg, work_next;
    logic               mode_inv;

    logic [31:0]        work_cols [4];
    logic [1:0]         col_sel   [COLS_PER_CYCLE];
    logic [31:0]        col_in    [COLS_PER_CYCLE];
    logic [31:0]        col_out   [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
    logic inv_reg, inv_next;
    assign mode_inv = inv_reg;
`else
    // Forward-only build: the mode is fixed and in_inv is never sampled.
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign mode_inv      = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cols
            assign work_cols[gi] = work_reg[127-32*gi -: 32];
        end

        // Unit gi handles column cnt*COLS_PER_CYCLE + gi on this BUSY edge.
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_units
            assign col_sel[gi] = 2'((int'(cnt_reg) * COLS_PER_CYCLE) + gi);
            assign col_in[gi]  = work_cols[col_sel[gi]];

            mix_column_unit u_col (
                .col_in  (col_in[gi]),
                .inv     (mode_inv),
                .col_out (col_out[gi])
            );
        end
    endgenerate

    // Next-state, counter and datapath update.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        work_next  = work_reg;
`ifdef MIXCOL_INV_EN
        inv_next   = inv_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = BUSY;
                    cnt_next   = '0;
                    work_next  = in_data;
`ifdef MIXCOL_INV_EN
                    inv_next   = in_inv;
`endif
                end
            end
            BUSY: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    work_next[127-32*int'(col_sel[i]) -: 32] = col_out[i];
                end
                if (cnt_reg == CNT_W'(K - 1)) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                // Returning to IDLE first keeps a waiting in_valid from
                // being taken on the same edge as the hand-off.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            work_reg  <= '0;
`ifdef MIXCOL_INV_EN
            inv_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            work_reg  <= work_next;
`ifdef MIXCOL_INV_EN
            inv_reg   <= inv_next;
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_data  = work_reg;

endmodule : mix_columns_engine

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: columns transformed per clock; legal values 1, 2, 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  input block offered.
REQ-005 SHALL have port in_ready  output  1  engine can accept a block.
REQ-006 SHALL have port in_data  input  128  AES state; column c at bits [127-32c -: 32], row 0 byte is the MSB of each column.
REQ-007 SHALL have port in_inv  input  1  0 = forward MixColumns, 1 = InvMixColumns; sampled with in_data.
REQ-008 SHALL have port out_valid  output  1  result held.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port out_data  output  128  transformed state, same layout as in_data.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 In IDLE, in_valid=1 at an edge SHALL capture in_data and in_inv, clear the column counter, and go to BUSY.
REQ-014 In BUSY, each edge SHALL replace COLS_PER_CYCLE columns of the working register in place, starting at column 0 (bits 127:96) and ascending.
REQ-015 After K = 4/COLS_PER_CYCLE BUSY edges, the FSM SHALL enter DONE, so out_valid rises exactly K cycles after the acceptance edge.
REQ-016 Forward mode SHALL compute each column as the GF(2^8) matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] times the column, modulo x^8+x^4+x^3+x+1 (xtime reduction constant 0x1B).
REQ-017 Inverse mode SHALL use the matrix [0E 0B 0D 09; 09 0E 0B 0D; 0D 09 0E 0B; 0B 0D 09 0E].
REQ-018 In DONE, out_data SHALL be stable until out_ready=1; at that edge the FSM SHALL return to IDLE.
REQ-019 Simultaneous out_ready in DONE and in_valid SHALL NOT accept the new block in the same cycle; it is accepted at the next IDLE edge, with no back-to-back overlap.
REQ-020 in_data and in_inv changes while busy=1 SHALL have no effect on the block in flight.
REQ-021 out_data SHALL present the working register in all states; only DONE contents are meaningful.
REQ-022 The column counter SHALL be ceil(log2(K)) bits wide, minimum 1, and SHALL wrap to 0 on the final BUSY edge.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, counter 0, working register 0, and captured mode 0.
REQ-024 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, out_data=128'h0.
REQ-025 Reset asserted mid-BUSY or mid-DONE SHALL abort the block with no partial result delivered.

Configuration
REQ-026 Macro MIXCOL_INV_EN defined: REQ-017 SHALL be implemented and in_inv honoured.
REQ-027 Macro MIXCOL_INV_EN undefined: in_inv SHALL be ignored, only forward logic SHALL be built, and timing SHALL be unchanged.

Structure
REQ-028 Package mixcol_pkg SHALL hold the FSM state typedef, the reduction constant 0x1B, and xtime/gf-multiply functions.
REQ-029 The single-column transform SHALL live in sub-module mix_column_unit (32-bit in, 32-bit out, inv input); the engine SHALL instantiate COLS_PER_CYCLE copies.
REQ-030 An illegal COLS_PER_CYCLE SHALL produce an elaboration-time error.

Verification
REQ-031 Forward, column 0 = db135345, columns 1-3 = f20a225c, 01010101, c6c6c6c6 -> out columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6.
REQ-032 Inverse with MIXCOL_INV_EN, input = REQ-031 output -> REQ-031 input restored; without the macro, in_inv=1 gives the forward result.
REQ-033 Latency for COLS_PER_CYCLE = 1, 2, 4 -> out_valid rises 4, 2, 1 cycles after acceptance; in_ready=0 throughout.
REQ-034 out_ready held 0 for 10 cycles in DONE -> out_data and out_valid stable; in_valid ignored; accepted 1 cycle after out_ready=1.
REQ-035 rst_n pulsed low in the 2nd BUSY cycle -> immediate in_ready=1, out_valid=0, out_data=0; the next block d4d4d4d5 gives d5d5d7d6 in column 0.
